// File: rtl/transmitter_arbiter.sv
// Round-robin arbiter that shares one nibble Transmitter among N_REQ requesters:
// it grants one requester, launches the Transmitter, follows busy to completion and acknowledges it.
module transmitter_arbiter #(
   parameter int N_REQ        = 4,
   parameter int ID_W         = 2,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [4*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic [ID_W-1:0]    grant_id,
   output logic               active,
   output logic               timeout_err,
   output logic [3:0]         tx_data_in,
   output logic               tx_start,
   input  logic               tx_busy
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_ACK
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               active_q, active_d;
   logic               timeout_err_q, timeout_err_d;
   logic [3:0]         tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;

   logic               sel_found;
   logic [ID_W-1:0]    sel_id;

   // First pending requester at or after the rotation pointer, wrapping.
   always_comb begin
      int unsigned idx;
      sel_found = 1'b0;
      sel_id    = '0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!sel_found && req[idx]) begin
            sel_found = 1'b1;
            sel_id    = ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      cnt_d         = cnt_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      ack_d         = '0;
      timeout_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // A busy Transmitter in IDLE belongs to someone else; do not launch.
            if (sel_found && !tx_busy) begin
               grant_id_d = sel_id;
               tx_data_d  = req_data[4*sel_id +: 4];
               tx_start_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
               ack_d[grant_id_q] = 1'b1;
               timeout_err_d     = 1'b1;
               state_d           = S_ACK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               ack_d[grant_id_q] = 1'b1;
               state_d           = S_ACK;
            end
         end
         S_ACK: begin
            ptr_d   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         grant_id_q    <= '0;
         cnt_q         <= '0;
         ack_q         <= '0;
         active_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         cnt_q         <= cnt_d;
         ack_q         <= ack_d;
         active_q      <= active_d;
         timeout_err_q <= timeout_err_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
      end
   end

   assign ack         = ack_q;
   assign grant_id    = grant_id_q;
   assign active      = active_q;
   assign timeout_err = timeout_err_q;
   assign tx_data_in  = tx_data_q;
   assign tx_start    = tx_start_q;

endmodule
